hls_layer_arbiter: RTL and testbench
====================================

# hls_layer_arbiter

Frame-level round-robin arbiter that shares one HLS-generated layer instance (din/dout valid-ready stream IP, e.g. a branch conv layer) between two requesters. It grants the layer to one requester for one complete frame: IN_WORDS input words forwarded to the layer and OUT_WORDS result words returned to the same requester. It sits between the requester streams and the `top_module_branch_*` layer wrapper in the FC subsystem.

## Interface
- IN_WIDTH, 32, layer input word width
- OUT_WIDTH, 8, layer output word width
- IN_WORDS, 16, input words per frame (>=1)
- OUT_WORDS, 4, output words per frame (>=1)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- req0_din_dat / req1_din_dat  in  IN_WIDTH  requester input data
- req0_din_vld / req1_din_vld  in  1  requester input valid
- req0_din_rdy / req1_din_rdy  out  1  requester input ready
- req0_dout_dat / req1_dout_dat  out  OUT_WIDTH  result data to requester
- req0_dout_vld / req1_dout_vld  out  1  result valid
- req0_dout_rdy / req1_dout_rdy  in  1  result ready
- layer_din_dat  out  IN_WIDTH  to layer din_rsc_dat
- layer_din_vld  out  1  to layer din_rsc_vld
- layer_din_rdy  in  1  from layer din_rsc_rdy
- layer_dout_dat  in  OUT_WIDTH  from layer dout_rsc_dat
- layer_dout_vld  in  1  from layer dout_rsc_vld
- layer_dout_rdy  out  1  to layer dout_rsc_rdy
- busy  out  1  frame in progress (state RUN)
- owner  out  1  current/last granted requester
- frame_done  out  1  one-cycle pulse on frame completion

## Operation
- States: IDLE, RUN.
- IDLE: all requester rdy/vld outputs 0, layer_din_vld=0, layer_dout_rdy=0. If any reqN_din_vld: grant; only one valid -> that one; both valid -> the one != last_grant. Registers owner, clears counters, -> RUN next cycle.
- RUN, input path (while in_cnt < IN_WORDS): combinational pass-through from owner: layer_din_dat/vld = owner dat/vld, owner din_rdy = layer_din_rdy. Non-owner din_rdy=0. in_cnt increments on layer handshake. After IN_WORDS handshakes layer_din_vld=0, owner din_rdy=0.
- RUN, output path (while out_cnt < OUT_WORDS): layer_dout_dat/vld routed to owner dout; layer_dout_rdy = owner dout_rdy. Non-owner dout_vld=0. out_cnt increments on handshake. Outputs may arrive before input completes (streaming layer); both paths run concurrently.
- Frame ends on the cycle both counts reach their limits (last input and last output handshakes may coincide): frame_done=1 for that cycle, last_grant<=owner, -> IDLE.
- Non-owner data held by its own valid; never dropped, never reordered.
- Counter widths: $clog2(IN_WORDS+1), $clog2(OUT_WORDS+1); no wrap, counters saturate at limit.

## Timing
- Reset (rst=0): state IDLE, owner=0, last_grant=1 (req0 wins first tie), counters 0, busy=0, frame_done=0, all vld/rdy outputs 0.
- Reset mid-frame: immediate abort, partial frame discarded; the layer shares rst and is cleared simultaneously.
- Arbitration bubble: 1 cycle (IDLE) between frames; first input word can transfer the cycle after grant.
- Forwarding adds zero latency (combinational vld/rdy/dat paths, no storage); minimum frame occupancy 1 + max(IN_WORDS, layer latency + OUT_WORDS) cycles.
- busy=1 exactly in RUN; owner stable throughout RUN.

## Structure
- Package hls_arb_pkg: state enum (IDLE, RUN), requester id typedef (logic [0:0]), REQ0/REQ1 constants.
- One sub-module: hls_frame_counter (parameter LIMIT; inputs clr, inc; outputs cnt, done), instantiated for input and output counts.
- Arbiter FSM and muxing in the top; no FIFOs.

## Test plan
- Single requester: req0 sends 16 words, layer model returns 4 -> req0 receives 4 words, frame_done pulses once, busy falls, owner=0.
- Contention: both valid from reset -> req0 frame first, then req1 after 1-cycle IDLE; repeated contention alternates 0,1,0,1.
- Backpressure: layer_din_rdy toggled 50%, req0_dout_rdy held 0 for 10 cycles -> no word lost/duplicated, layer_dout_rdy=0 while held.
- Early output: layer emits output word during input word 3 -> routed to owner immediately; frame ends only after 16th input and 4th output.
- Coincident completion: last input and last output handshake same cycle -> frame_done that cycle, IDLE next.
- Reset mid-frame after 7 inputs -> all outputs 0 next edge, busy=0; following frame from req1 completes with full 16/4 counts.

Source files
------------

// File: rtl/hls_arb_pkg.sv
// Purpose: shared types for the frame-level layer arbiter (FSM states, requester ids).
// Latency: n/a (types only).
// Backpressure: n/a.
package hls_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } arb_state_t;

    typedef logic [0:0] req_id_t;

    localparam req_id_t REQ0 = 1'b0;
    localparam req_id_t REQ1 = 1'b1;

endpackage

// File: rtl/hls_layer_arbiter_if.sv
// Purpose: one dat/vld/rdy stream link between a producer (master) and a consumer (slave).
// Latency: none, wires only.
// Backpressure: consumer drives rdy; a word moves on a cycle with vld and rdy both high.
interface hls_layer_arbiter_if #(
    parameter int W = 8
);
    logic [W-1:0] dat;
    logic         vld;
    logic         rdy;

    modport master (output dat, output vld, input rdy);
    modport slave  (input dat, input vld, output rdy);
endinterface

// File: rtl/hls_frame_counter.sv
// Purpose: per-frame word counter that stops at LIMIT; done flags the limit.
// Latency: cnt/done update the cycle after inc; clr takes priority over inc.
// Backpressure: none; increments are ignored once the limit is reached.
module hls_frame_counter #(
    parameter int LIMIT = 16,
    localparam int CW   = $clog2(LIMIT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          done
);

    assign done = (cnt == CW'(LIMIT));

    // Count accepted words, saturating at LIMIT so the count never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !done) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hls_layer_arbiter.sv
// Purpose: frame-level round-robin sharing of one streaming layer between two requesters.
// Latency: one IDLE arbitration cycle per frame; data/vld/rdy forwarded combinationally.
// Backpressure: owner sees the layer's rdy and the layer sees the owner's rdy; non-owner is held off.
module hls_layer_arbiter
    import hls_arb_pkg::*;
#(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8,
    parameter int IN_WORDS  = 16,
    parameter int OUT_WORDS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    hls_layer_arbiter_if.slave         req0_din,
    hls_layer_arbiter_if.slave         req1_din,
    hls_layer_arbiter_if.master        req0_dout,
    hls_layer_arbiter_if.master        req1_dout,
    hls_layer_arbiter_if.master        layer_din,
    hls_layer_arbiter_if.slave         layer_dout,
    output logic                       busy,
    output req_id_t                    owner,
    output logic                       frame_done
);

    localparam int ICW = $clog2(IN_WORDS + 1);
    localparam int OCW = $clog2(OUT_WORDS + 1);

    arb_state_t            state_q, state_d;
    req_id_t               owner_q, last_q, grant;
    logic                  start;
    logic                  in_act, out_act, in_hs, out_hs;
    logic                  in_done, out_done, in_fin, out_fin;
    logic [ICW-1:0]        in_cnt;
    logic [OCW-1:0]        out_cnt;
    logic                  own_din_vld, own_dout_rdy;
    logic [IN_WIDTH-1:0]   own_din_dat;
    logic [OUT_WIDTH-1:0]  dout_dat;

    // Owner-side selections; owner_q only changes in IDLE so these are stable through a frame.
    assign own_din_vld  = (owner_q == REQ1) ? req1_din.vld  : req0_din.vld;
    assign own_din_dat  = (owner_q == REQ1) ? req1_din.dat  : req0_din.dat;
    assign own_dout_rdy = (owner_q == REQ1) ? req1_dout.rdy : req0_dout.rdy;
    assign dout_dat     = layer_dout.dat;

    assign in_hs  = in_act  && own_din_vld     && layer_din.rdy;
    assign out_hs = out_act && layer_dout.vld  && own_dout_rdy;

    // A path is finished if it already hit its limit or its last word moves this cycle.
    assign in_fin  = in_done  || (in_hs  && (in_cnt  == ICW'(IN_WORDS - 1)));
    assign out_fin = out_done || (out_hs && (out_cnt == OCW'(OUT_WORDS - 1)));

    // Next-state, grant choice and frame completion.
    always_comb begin
        state_d    = state_q;
        grant      = owner_q;
        start      = 1'b0;
        frame_done = 1'b0;
        in_act     = 1'b0;
        out_act    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0_din.vld || req1_din.vld) begin
                    start   = 1'b1;
                    state_d = RUN;
                    if (req0_din.vld && req1_din.vld) begin
                        grant = ~last_q;
                    end else if (req1_din.vld) begin
                        grant = REQ1;
                    end else begin
                        grant = REQ0;
                    end
                end
            end
            RUN: begin
                in_act  = !in_done;
                out_act = !out_done;
                if (in_fin && out_fin) begin
                    frame_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, owner and round-robin history registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= REQ0;
            last_q  <= REQ1;
        end else begin
            state_q <= state_d;
            if (start) begin
                owner_q <= grant;
            end
            if (frame_done) begin
                last_q <= owner_q;
            end
        end
    end

    hls_frame_counter #(.LIMIT(IN_WORDS)) u_in_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (start),
        .inc  (in_hs),
        .cnt  (in_cnt),
        .done (in_done)
    );

    hls_frame_counter #(.LIMIT(OUT_WORDS)) u_out_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (start),
        .inc  (out_hs),
        .cnt  (out_cnt),
        .done (out_done)
    );

    assign layer_din.vld  = in_act && own_din_vld;
    assign layer_din.dat  = own_din_dat;
    assign req0_din.rdy   = in_act && (owner_q == REQ0) && layer_din.rdy;
    assign req1_din.rdy   = in_act && (owner_q == REQ1) && layer_din.rdy;

    assign layer_dout.rdy = out_act && own_dout_rdy;
    assign req0_dout.vld  = out_act && (owner_q == REQ0) && layer_dout.vld;
    assign req1_dout.vld  = out_act && (owner_q == REQ1) && layer_dout.vld;
    assign req0_dout.dat  = dout_dat;
    assign req1_dout.dat  = dout_dat;

    assign busy  = (state_q == RUN);
    assign owner = owner_q;

endmodule

// File: tb/tb_hls_layer_arbiter.sv
// Purpose: randomized bench for hls_layer_arbiter with a frame-level reference model and output scoreboard.
// Latency: inputs driven on negedge, everything sampled 1 time unit before posedge.
// Backpressure: random layer/sink readiness, a forced sink hold, early and coincident layer outputs.
module tb_hls_layer_arbiter;
    import hls_arb_pkg::*;

    localparam int IW = 32;
    localparam int OW = 8;
    localparam int NI = 16;
    localparam int NO = 4;

    logic    clk = 1'b0;
    logic    rst = 1'b0;
    logic    busy, frame_done;
    req_id_t owner;

    always #5 clk = ~clk;

    hls_layer_arbiter_if #(.W(IW)) req0_din (), req1_din (), layer_din ();
    hls_layer_arbiter_if #(.W(OW)) req0_dout (), req1_dout (), layer_dout ();

    hls_layer_arbiter #(
        .IN_WIDTH  (IW),
        .OUT_WIDTH (OW),
        .IN_WORDS  (NI),
        .OUT_WORDS (NO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_din   (req0_din),
        .req1_din   (req1_din),
        .req0_dout  (req0_dout),
        .req1_dout  (req1_dout),
        .layer_din  (layer_din),
        .layer_dout (layer_dout),
        .busy       (busy),
        .owner      (owner),
        .frame_done (frame_done)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Stimulus queues and the scoreboard of expected result bytes per requester.
    logic [31:0] tx0[$], tx1[$];
    logic [7:0]  exp0[$], exp1[$];
    int          seq = 0;
    int          frames_exp = 0;

    // Knobs.
    int p_in = 100, p_out = 100, p_sink = 100, hold0 = 0;
    bit coincide = 1'b0;

    // Frame-level reference model.
    bit m_busy = 1'b0, m_own = 1'b0, m_last = 1'b1;
    int m_in = 0, m_out = 0;

    // Layer stub state.
    int         l_in = 0;
    logic [7:0] l_q[$];

    // Observations.
    req_id_t dut_grants[$];
    bit      busy_prev = 1'b0;
    int      done_cnt = 0, coinc_cnt = 0, early_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic rnd(input int p);
        return int'($urandom_range(99)) < p;
    endfunction

    // A frame: 16 tagged words; the layer returns bytes of the first word xor'd with the index.
    task automatic add_frame(input bit id);
        logic [31:0] w, w0;
        w0 = '0;
        for (int i = 0; i < NI; i++) begin
            w = {id, 7'(seq), 8'(i), 16'($urandom)};
            if (i == 0) w0 = w;
            if (id) tx1.push_back(w); else tx0.push_back(w);
        end
        for (int k = 0; k < NO; k++) begin
            if (id) exp1.push_back(w0[8*k +: 8] ^ 8'(k));
            else    exp0.push_back(w0[8*k +: 8] ^ 8'(k));
        end
        seq++;
        frames_exp++;
    endtask

    // One clock: drive at negedge, sample just before posedge, step the model, wait next negedge.
    task automatic cycle();
        logic        v0, v1, ov, srdy, hs_in, hs_out, done_e;
        logic [31:0] ovd, w;
        logic [5:0]  e_ctl;
        req0_din.vld  = (tx0.size() > 0);
        req0_din.dat  = (tx0.size() > 0) ? tx0[0] : '0;
        req1_din.vld  = (tx1.size() > 0);
        req1_din.dat  = (tx1.size() > 0) ? tx1[0] : '0;
        req0_dout.rdy = (hold0 > 0) ? 1'b0 : rnd(p_sink);
        if (hold0 > 0) hold0--;
        req1_dout.rdy = rnd(p_sink);
        layer_din.rdy = rnd(p_in);
        if (coincide) layer_dout.vld = (l_q.size() > 0) && (l_in == NI - l_q.size());
        else          layer_dout.vld = (l_q.size() > 0) && rnd(p_out);
        layer_dout.dat = (l_q.size() > 0) ? l_q[0] : '0;
        #4;
        if (!rst) begin
            chk("reset_outputs", 32'({busy, frame_done, owner, req0_din.rdy, req1_din.rdy,
                req0_dout.vld, req1_dout.vld, layer_din.vld, layer_dout.rdy}), 32'd0);
            m_busy = 1'b0; m_own = 1'b0; m_last = 1'b1; m_in = 0; m_out = 0;
            l_in = 0; l_q.delete(); busy_prev = 1'b0;
        end else begin
            v0     = req0_din.vld;
            v1     = req1_din.vld;
            ov     = m_own ? v1 : v0;
            ovd    = m_own ? req1_din.dat : req0_din.dat;
            srdy   = m_own ? req1_dout.rdy : req0_dout.rdy;
            hs_in  = m_busy && (m_in < NI) && ov && layer_din.rdy;
            hs_out = m_busy && (m_out < NO) && layer_dout.vld && srdy;
            done_e = m_busy && (m_in + int'(hs_in) == NI) && (m_out + int'(hs_out) == NO);
            e_ctl  = {m_busy && (m_in < NI) && ov,
                      m_busy && (m_out < NO) && srdy,
                      m_busy && !m_own && (m_in < NI) && layer_din.rdy,
                      m_busy &&  m_own && (m_in < NI) && layer_din.rdy,
                      m_busy && !m_own && (m_out < NO) && layer_dout.vld,
                      m_busy &&  m_own && (m_out < NO) && layer_dout.vld};
            chk("busy", 32'(busy), 32'(m_busy));
            chk("owner", 32'(owner), 32'(m_own));
            chk("frame_done", 32'(frame_done), 32'(done_e));
            chk("handshake_ctl", 32'({layer_din.vld, layer_dout.rdy, req0_din.rdy, req1_din.rdy,
                req0_dout.vld, req1_dout.vld}), 32'(e_ctl));
            if (e_ctl[5]) chk("layer_din_dat", layer_din.dat, ovd);
            // Observations of the DUT.
            if (busy && !busy_prev) dut_grants.push_back(owner);
            busy_prev = busy;
            if (frame_done) done_cnt++;
            if (frame_done && layer_din.vld && layer_din.rdy && layer_dout.vld && layer_dout.rdy)
                coinc_cnt++;
            if (hs_out && m_in < NI) early_cnt++;
            // Requester sources.
            if (req0_din.vld && req0_din.rdy) void'(tx0.pop_front());
            if (req1_din.vld && req1_din.rdy) void'(tx1.pop_front());
            // Layer stub.
            if (layer_din.vld && layer_din.rdy) begin
                w = layer_din.dat;
                chk("layer_word_order", 32'(w[23:16]), 32'(l_in));
                chk("layer_word_src", 32'(w[31]), 32'(m_own));
                if (l_in == 0)
                    for (int k = 0; k < NO; k++) l_q.push_back(w[8*k +: 8] ^ 8'(k));
                l_in = (l_in + 1) % NI;
            end
            if (layer_dout.vld && layer_dout.rdy && l_q.size() > 0) void'(l_q.pop_front());
            // Reference model step.
            if (!m_busy) begin
                if (v0 || v1) begin
                    m_own  = (v0 && v1) ? !m_last : v1;
                    m_busy = 1'b1;
                    m_in   = 0;
                    m_out  = 0;
                end
            end else begin
                m_in  += int'(hs_in);
                m_out += int'(hs_out);
                if (done_e) begin
                    m_busy = 1'b0;
                    m_last = m_own;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic run_until_idle(input string name, input int max_cycles);
        int k;
        k = 0;
        while (!(tx0.size() == 0 && tx1.size() == 0 && exp0.size() == 0 && exp1.size() == 0 && !m_busy)
               && k < max_cycles) begin
            cycle();
            k++;
        end
        chk({"drained_", name}, 32'(k < max_cycles), 32'd1);
        cycle();
    endtask

    // Scoreboard monitor: pops the expected byte whenever a requester accepts a result.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                if (req0_dout.vld && req0_dout.rdy) begin
                    if (exp0.size() == 0) chk("dout0_unexpected", 32'd1, 32'd0);
                    else chk("dout0_data", 32'(req0_dout.dat), 32'(exp0.pop_front()));
                end
                if (req1_dout.vld && req1_dout.rdy) begin
                    if (exp1.size() == 0) chk("dout1_unexpected", 32'd1, 32'd0);
                    else chk("dout1_data", 32'(req1_dout.dat), 32'(exp1.pop_front()));
                end
            end
        end
    end

    initial begin
        int k;
        req0_din.vld = 1'b0; req0_din.dat = '0; req1_din.vld = 1'b0; req1_din.dat = '0;
        req0_dout.rdy = 1'b0; req1_dout.rdy = 1'b0;
        layer_din.rdy = 1'b0; layer_dout.vld = 1'b0; layer_dout.dat = '0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) cycle();
        rst = 1'b1;

        // Contention from reset: grants must alternate starting with req0.
        add_frame(1'b0); add_frame(1'b0); add_frame(1'b1); add_frame(1'b1);
        run_until_idle("contention", 400);
        chk("grant_count", 32'(dut_grants.size()), 32'd4);
        for (int i = 0; i < 4 && i < dut_grants.size(); i++)
            chk("grant_order", 32'(dut_grants[i]), 32'(i % 2));
        dut_grants.delete();

        // Single requester.
        add_frame(1'b0);
        run_until_idle("single", 200);
        chk("single_grant", 32'(dut_grants.size() > 0 ? dut_grants[0] : 1'b1), 32'd0);
        chk("single_owner_after", 32'(owner), 32'd0);
        chk("single_busy_after", 32'(busy), 32'd0);

        // Backpressure with a 10-cycle hold on req0's result sink.
        p_in = 50; p_out = 60; p_sink = 70;
        add_frame(1'b0); add_frame(1'b0); add_frame(1'b1);
        for (int i = 0; i < 5; i++) cycle();
        hold0 = 10;
        run_until_idle("backpressure", 1500);

        // Early output: results flow while inputs are still trickling in.
        p_in = 25; p_out = 100; p_sink = 100;
        add_frame(1'b1);
        run_until_idle("early", 600);
        chk("early_output_seen", 32'(early_cnt > 0), 32'd1);

        // Last input and last output handshake in the same cycle.
        p_in = 100; coincide = 1'b1;
        add_frame(1'b0);
        run_until_idle("coincident", 200);
        chk("coincident_done_seen", 32'(coinc_cnt > 0), 32'd1);
        coincide = 1'b0;

        // Reset after 7 inputs, then a clean frame from req1.
        add_frame(1'b0);
        k = 0;
        while (l_in != 7 && k < 200) begin
            cycle();
            k++;
        end
        chk("reached_7_inputs", 32'(l_in), 32'd7);
        rst = 1'b0;
        tx0.delete(); exp0.delete(); frames_exp--;
        cycle();
        cycle();
        rst = 1'b1;
        add_frame(1'b1);
        run_until_idle("after_reset", 200);
        chk("post_reset_owner", 32'(owner), 32'd1);

        chk("frame_done_count", 32'(done_cnt), 32'(frames_exp));
        chk("layer_results_left", 32'(l_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
